insight_tlc_burst_tracker: RTL and testbench
============================================

// Module: insight_tlc_burst_tracker
// PURPOSE
// - Passive consumer of one hart's instruction-side TileLink channel C (Release/ProbeAck).
// - Snoops ready/valid fires, reassembles multi-beat messages and checks in-burst field stability.
// - Pushes one summary record per completed message into a FIFO for the Insight trace encoder.
// - Never drives channel C; it is an observer only.
// PARAMETERS
// - DEPTH     4  record FIFO entries; power of two, >=2.
// - MAX_SIZE  6  largest legal c_size (log2 bytes); 6 = 64B = 16 beats on a 32-bit bus.
// - CNT_W     8  width of the saturating drop counter.
// PORTS
// - clock        in   1   single clock.
// - reset        in   1   asynchronous, active-high reset.
// - c_valid      in   1   channel C valid, snooped.
// - c_ready      in   1   channel C ready, snooped; beat fires when c_valid & c_ready.
// - c_opcode     in   3   TL-C opcode; opcode[0]=1 means a data-bearing message.
// - c_param      in   3   TL-C param.
// - c_size       in   4   log2 transfer bytes.
// - c_source     in   1   source id.
// - c_address    in   32  byte address.
// - c_data       in   32  beat data.
// - c_corrupt    in   1   beat corrupt flag.
// - rec_valid    out  1   FIFO head record valid.
// - rec_ready    in   1   consumer accepts head record.
// - rec_opcode   out  3   captured opcode.
// - rec_param    out  3   captured param.
// - rec_size     out  4   captured size.
// - rec_source   out  1   captured source.
// - rec_address  out  32  captured address.
// - rec_beats    out  5   beats observed (1..16).
// - rec_corrupt  out  1   OR of c_corrupt over all beats.
// - rec_data_xor out  32  XOR of c_data over all beats; 0 when the message has no data.
// - busy         out  1   1 while in BURST.
// - drop_count   out  CNT_W  records lost to a full FIFO; saturates at all-ones.
// - err_size     out  1   sticky: data message seen with c_size > MAX_SIZE.
// - err_field    out  1   sticky: opcode/param/size/source/address changed mid-burst.
// BEHAVIOUR
// - Reset: FSM->IDLE, FIFO empty, rec_valid=0, all rec_* = 0, busy=0, drop_count=0, both err flags 0.
// - Reset mid-burst discards the partial message; nothing is pushed.
// - Expected beat count: non-data -> 1; data with size<=2 -> 1; otherwise 1<<(size-2).
// - Oversize data message: size clamps to MAX_SIZE for counting and err_size is set.
// - IDLE, on a fire:
//   - capture all fields, init corrupt/xor from this beat, beats=1.
//   - if expected beats = 1: push the record and stay in IDLE; else go to BURST.
// - BURST, on a fire:
//   - compare fields with the captured copy; any mismatch sets err_field, but the beat still counts.
//   - accumulate corrupt and xor, beats++.
//   - on the last beat: push the record, go to IDLE.
// - No fire: hold state. c_valid without c_ready is ignored.
// - Push timing: the record is visible on rec_valid in the cycle after the last-beat fire (1-cycle latency).
// - FIFO pop when rec_valid & rec_ready. rec_* hold stable while rec_valid & !rec_ready.
// - Push while full: accepted only if a pop occurs the same cycle. Otherwise the record is dropped and drop_count++ (saturating).
// - Push and pop in the same cycle when empty: the record appears next cycle; no bypass.
// - Pointers are log2(DEPTH)+1 bits wide with a wrap bit; full/empty come from the pointer compare.
// TESTING
// - ProbeAck (op=4, size=6), one fire -> next cycle rec_valid=1, rec_beats=1, rec_data_xor=0, busy stays 0.
// - ReleaseData (op=7, size=6, addr=0x8000_0040), 16 beats of data=i -> rec_beats=16, rec_data_xor=0x0, rec_address=0x8000_0040.
// - ProbeAckData (op=5, size=4), 4 beats, corrupt only on beat 2, c_ready low every other cycle -> rec_corrupt=1, rec_beats=4, exactly 4 fires counted.
// - rec_ready=0, push 5 single-beat messages with DEPTH=4 -> 4 held, drop_count=1. Pop all -> records come out in push order.
// - ReleaseData (size=4) with c_address changed on beat 3 -> err_field=1, record still pushed, rec_beats=4.
// - Assert reset after beat 2 of an 8-beat burst -> busy=0, rec_valid=0, no record. The next 1-beat message is tracked normally.

Source files
------------

// File: rtl/insight_tlc_burst_tracker.sv
// Passive TileLink channel C snooper: reassembles multi-beat Release/ProbeAck messages,
// checks in-burst field stability and queues one summary record per message.
module insight_tlc_burst_tracker #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_SIZE = 6,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             c_valid,
   input  logic             c_ready,
   input  logic [2:0]       c_opcode,
   input  logic [2:0]       c_param,
   input  logic [3:0]       c_size,
   input  logic             c_source,
   input  logic [31:0]      c_address,
   input  logic [31:0]      c_data,
   input  logic             c_corrupt,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [2:0]       rec_opcode,
   output logic [2:0]       rec_param,
   output logic [3:0]       rec_size,
   output logic             rec_source,
   output logic [31:0]      rec_address,
   output logic [4:0]       rec_beats,
   output logic             rec_corrupt,
   output logic [31:0]      rec_data_xor,
   output logic             busy,
   output logic [CNT_W-1:0] drop_count,
   output logic             err_size,
   output logic             err_field
);

   localparam int unsigned PW      = $clog2(DEPTH);
   localparam logic [3:0]  MaxSize = 4'(MAX_SIZE);

   typedef struct packed {
      logic [2:0]  opcode;
      logic [2:0]  param;
      logic [3:0]  size;
      logic        source;
      logic [31:0] address;
      logic [4:0]  beats;
      logic        corrupt;
      logic [31:0] data_xor;
   } rec_t;

   typedef enum logic {StIdle, StBurst} state_t;

   state_t            state_q, state_d;
   rec_t              cap_q, cap_d;
   logic [4:0]        exp_q, exp_d, exp_beats;
   logic [3:0]        eff_size;
   logic              err_size_q, err_size_d, err_field_q, err_field_d;
   logic              fire, push, pop, full, empty, wr_en, drop, mismatch;
   logic [PW:0]       wr_ptr_q, rd_ptr_q;
   rec_t              mem_q [DEPTH];
   rec_t              head;
   logic [CNT_W-1:0]  drop_q;

   assign fire = c_valid & c_ready;

   // Oversize data messages are counted as MAX_SIZE bursts.
   always_comb begin
      eff_size = (c_size > MaxSize) ? MaxSize : c_size;
      if (!c_opcode[0] || eff_size <= 4'd2) begin
         exp_beats = 5'd1;
      end else begin
         exp_beats = 5'd1 << (eff_size - 4'd2);
      end
   end

   assign mismatch = (c_opcode != cap_q.opcode) || (c_param != cap_q.param) ||
                     (c_size != cap_q.size) || (c_source != cap_q.source) ||
                     (c_address != cap_q.address);

   always_comb begin
      state_d     = state_q;
      cap_d       = cap_q;
      exp_d       = exp_q;
      push        = 1'b0;
      err_size_d  = err_size_q;
      err_field_d = err_field_q;
      unique case (state_q)
         StIdle: begin
            if (fire) begin
               cap_d.opcode   = c_opcode;
               cap_d.param    = c_param;
               cap_d.size     = c_size;
               cap_d.source   = c_source;
               cap_d.address  = c_address;
               cap_d.beats    = 5'd1;
               cap_d.corrupt  = c_corrupt;
               cap_d.data_xor = c_opcode[0] ? c_data : 32'd0;
               exp_d          = exp_beats;
               if (c_opcode[0] && (c_size > MaxSize)) begin
                  err_size_d = 1'b1;
               end
               if (exp_beats == 5'd1) begin
                  push = 1'b1;
               end else begin
                  state_d = StBurst;
               end
            end
         end
         StBurst: begin
            if (fire) begin
               if (mismatch) begin
                  err_field_d = 1'b1;
               end
               cap_d.beats    = cap_q.beats + 5'd1;
               cap_d.corrupt  = cap_q.corrupt | c_corrupt;
               cap_d.data_xor = cap_q.data_xor ^ c_data;
               if (cap_d.beats == exp_q) begin
                  push    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cap_q       <= '0;
         exp_q       <= 5'd0;
         err_size_q  <= 1'b0;
         err_field_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_q       <= cap_d;
         exp_q       <= exp_d;
         err_size_q  <= err_size_d;
         err_field_q <= err_field_d;
      end
   end

   // Record FIFO; the extra pointer bit distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop   = !empty && rec_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (drop && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[PW-1:0]] <= cap_d;
      end
   end

   assign head         = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
   assign rec_valid    = !empty;
   assign rec_opcode   = head.opcode;
   assign rec_param    = head.param;
   assign rec_size     = head.size;
   assign rec_source   = head.source;
   assign rec_address  = head.address;
   assign rec_beats    = head.beats;
   assign rec_corrupt  = head.corrupt;
   assign rec_data_xor = head.data_xor;
   assign busy         = (state_q == StBurst);
   assign drop_count   = drop_q;
   assign err_size     = err_size_q;
   assign err_field    = err_field_q;

endmodule

// File: tb/tb_insight_tlc_burst_tracker.sv
// Bench for insight_tlc_burst_tracker: directed messages, a queue model of the record FIFO
// checked every cycle, and hand-computed literal expectations.
module tb_insight_tlc_burst_tracker;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        c_valid = 1'b0, c_ready = 1'b0;
   logic [2:0]  c_opcode = '0, c_param = '0;
   logic [3:0]  c_size = '0;
   logic        c_source = 1'b0;
   logic [31:0] c_address = '0, c_data = '0;
   logic        c_corrupt = 1'b0;
   logic        rec_valid, rec_ready = 1'b1;
   logic [2:0]  rec_opcode, rec_param;
   logic [3:0]  rec_size;
   logic        rec_source;
   logic [31:0] rec_address;
   logic [4:0]  rec_beats;
   logic        rec_corrupt;
   logic [31:0] rec_data_xor;
   logic        busy;
   logic [7:0]  drop_count;
   logic        err_size, err_field;

   insight_tlc_burst_tracker #(.DEPTH(DEPTH), .MAX_SIZE(6), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
      .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
      .c_corrupt(c_corrupt),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_opcode(rec_opcode),
      .rec_param(rec_param), .rec_size(rec_size), .rec_source(rec_source),
      .rec_address(rec_address), .rec_beats(rec_beats), .rec_corrupt(rec_corrupt),
      .rec_data_xor(rec_data_xor), .busy(busy), .drop_count(drop_count),
      .err_size(err_size), .err_field(err_field)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0]  op;
      logic [2:0]  param;
      logic [3:0]  size;
      logic        src;
      logic [31:0] addr;
      logic [4:0]  beats;
      logic        corrupt;
      logic [31:0] dx;
   } rec_t;

   rec_t        mq[$];
   rec_t        pend_rec;
   logic        pend_valid = 1'b0;
   int unsigned model_drop = 0;
   logic        exp_busy = 1'b0, exp_err_size = 1'b0, exp_err_field = 1'b0;
   int          vectors = 0, miscompares = 0;
   logic [31:0] bd[16];
   logic        bc[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Record queue: pops what the consumer takes, then pushes a finished message or counts a drop.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
         model_drop = 0;
         pend_valid = 1'b0;
      end else begin
         if (mq.size() != 0 && rec_ready) void'(mq.pop_front());
         if (pend_valid) begin
            if (mq.size() < DEPTH) mq.push_back(pend_rec);
            else if (model_drop < 255) model_drop++;
            pend_valid = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         check("rec_valid", 32'(rec_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            check("rec_opcode", 32'(rec_opcode), 32'(mq[0].op));
            check("rec_param", 32'(rec_param), 32'(mq[0].param));
            check("rec_size", 32'(rec_size), 32'(mq[0].size));
            check("rec_source", 32'(rec_source), 32'(mq[0].src));
            check("rec_address", rec_address, mq[0].addr);
            check("rec_beats", 32'(rec_beats), 32'(mq[0].beats));
            check("rec_corrupt", 32'(rec_corrupt), 32'(mq[0].corrupt));
            check("rec_data_xor", rec_data_xor, mq[0].dx);
         end
         check("busy", 32'(busy), 32'(exp_busy));
         check("drop_count", 32'(drop_count), 32'(model_drop));
         check("err_size", 32'(err_size), 32'(exp_err_size));
         check("err_field", 32'(err_field), 32'(exp_err_field));
      end
   end

   // Drives n beats from bd/bc; bad = beat index whose address is perturbed (-1 = none).
   task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                       input logic src, input logic [31:0] addr, input int n, input bit stall,
                       input int bad, input bit complete);
      rec_t r;
      r = '{op: op, param: param, size: size, src: src, addr: addr, beats: 5'(n),
            corrupt: 1'b0, dx: 32'd0};
      for (int i = 0; i < n; i++) begin
         r.corrupt = r.corrupt | bc[i];
         if (op[0]) r.dx = r.dx ^ bd[i];
      end
      for (int i = 0; i < n; i++) begin
         for (int s = (stall ? 0 : 1); s < 2; s++) begin
            @(negedge clock);
            c_valid   = 1'b1;
            c_ready   = (s == 1);
            c_opcode  = op;
            c_param   = param;
            c_size    = size;
            c_source  = src;
            c_address = (i == bad) ? (addr ^ 32'h100) : addr;
            c_data    = bd[i];
            c_corrupt = bc[i];
            if (s == 1 && i == n - 1 && complete) begin
               pend_rec   = r;
               pend_valid = 1'b1;
            end
            @(posedge clock);
            if (s == 1) begin
               if (i == 0 && op[0] && size > 4'd6) exp_err_size = 1'b1;
               if (i == bad && i > 0) exp_err_field = 1'b1;
               exp_busy = complete ? (i != n - 1) : 1'b1;
            end
         end
      end
      @(negedge clock);
      c_valid = 1'b0;
      c_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         bd[i] = 32'd0;
         bc[i] = 1'b0;
      end
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset rec_valid", 32'(rec_valid), 32'd0);
      check("reset rec_address", rec_address, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset drop_count", 32'(drop_count), 32'd0);
      #2 reset = 1'b0;

      // ProbeAck: single beat, no data
      bd[0] = 32'hDEADBEEF;
      send(3'd4, 3'd1, 4'd6, 1'b1, 32'h0000_1000, 1, 1'b0, -1, 1'b1);
      check("probeack rec_valid", 32'(rec_valid), 32'd1);
      check("probeack rec_beats", 32'(rec_beats), 32'd1);
      check("probeack rec_data_xor", rec_data_xor, 32'd0);
      check("probeack busy", 32'(busy), 32'd0);

      // Oversize size on a non-data message is not an error
      send(3'd4, 3'd0, 4'd9, 1'b0, 32'h0000_2000, 1, 1'b0, -1, 1'b1);
      check("nodata oversize err_size", 32'(err_size), 32'd0);

      // ReleaseData, 16 beats of data=i
      for (int i = 0; i < 16; i++) bd[i] = 32'(i);
      send(3'd7, 3'd0, 4'd6, 1'b0, 32'h8000_0040, 16, 1'b0, -1, 1'b1);
      check("release16 rec_beats", 32'(rec_beats), 32'd16);
      check("release16 rec_data_xor", rec_data_xor, 32'd0);
      check("release16 rec_address", rec_address, 32'h8000_0040);

      // ProbeAckData, 4 beats, corrupt on beat 2, ready toggling
      for (int i = 0; i < 4; i++) bd[i] = 32'hA5A5_0000 | 32'(i + 1);
      bc[2] = 1'b1;
      send(3'd5, 3'd2, 4'd4, 1'b1, 32'h0000_3000, 4, 1'b1, -1, 1'b1);
      bc[2] = 1'b0;
      check("pad4 rec_corrupt", 32'(rec_corrupt), 32'd1);
      check("pad4 rec_beats", 32'(rec_beats), 32'd4);
      check("pad4 rec_data_xor", rec_data_xor, 32'h0000_0004);

      // Five single-beat messages into a stalled FIFO of four
      repeat (2) @(negedge clock);
      rec_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         send(3'd4, 3'd0, 4'd2, 1'b0, 32'h0000_4000 + 32'(k) * 32'h10, 1, 1'b0, -1, 1'b1);
      check("full drop_count", 32'(drop_count), 32'd1);
      check("full head address", rec_address, 32'h0000_4000);
      rec_ready = 1'b1;
      repeat (6) @(negedge clock);
      check("drained rec_valid", 32'(rec_valid), 32'd0);

      // ReleaseData with the address changed on beat 3
      for (int i = 0; i < 4; i++) bd[i] = 32'h1000 << i;
      send(3'd7, 3'd0, 4'd4, 1'b0, 32'h0000_5000, 4, 1'b0, 2, 1'b1);
      check("field err_field", 32'(err_field), 32'd1);
      check("field rec_beats", 32'(rec_beats), 32'd4);
      check("field rec_address", rec_address, 32'h0000_5000);
      check("field rec_data_xor", rec_data_xor, 32'h0000_F000);

      // Oversize data message clamps to 16 beats
      for (int i = 0; i < 16; i++) bd[i] = 32'(i * 3);
      send(3'd7, 3'd1, 4'd8, 1'b1, 32'h0000_A000, 16, 1'b0, -1, 1'b1);
      check("oversize err_size", 32'(err_size), 32'd1);
      check("oversize rec_beats", 32'(rec_beats), 32'd16);

      // Reset after beat 2 of an 8-beat burst
      for (int i = 0; i < 8; i++) bd[i] = 32'(i);
      send(3'd7, 3'd0, 4'd5, 1'b1, 32'h0000_6000, 2, 1'b0, -1, 1'b0);
      check("midburst busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      exp_busy      = 1'b0;
      exp_err_size  = 1'b0;
      exp_err_field = 1'b0;
      #1;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset rec_valid", 32'(rec_valid), 32'd0);
      check("midreset err_field", 32'(err_field), 32'd0);
      check("midreset drop_count", 32'(drop_count), 32'd0);
      @(negedge clock);
      #2 reset = 1'b0;
      send(3'd6, 3'd0, 4'd3, 1'b0, 32'h0000_7000, 1, 1'b0, -1, 1'b1);
      check("after reset rec_valid", 32'(rec_valid), 32'd1);
      check("after reset rec_beats", 32'(rec_beats), 32'd1);
      check("after reset rec_address", rec_address, 32'h0000_7000);
      repeat (3) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
